// File: rtl/switch_debouncer.sv
// ---------------------------------------------------------------------------
// switch_debouncer
//
// Conditions the raw board DIP switches for the CPU's memory-mapped switch
// read port. Each switch line is synchronised into the CPU clock domain with
// a two-flop chain and then debounced independently. A shared free-running
// prescaler produces a sample tick every TICK_DIV cycles. A bit is accepted
// only after its synchronised value has differed from the published value on
// STABLE_TICKS consecutive ticks with no intervening match.
//
// Parameters
//   WIDTH         number of switch lines (>= 1)
//   TICK_DIV      clock cycles per sample tick (>= 2)
//   STABLE_TICKS  consecutive differing ticks needed to accept a change (>= 1)
//
// Ports
//   iCpuClock       in   1      CPU clock, posedge
//   iCpuReset       in   1      asynchronous active-high reset, clears everything
//   iRawSwitches    in   WIDTH  raw switch pins, asynchronous to iCpuClock
//   oSwitches       out  WIDTH  debounced switch word
//   oSwitchChanged  out  1      one-cycle pulse when any bit of oSwitches updates
//   oChangedMask    out  WIDTH  one-cycle per-bit mask of the updated bits
//
// Optional feature (macro SWITCH_STICKY_EN)
//   iStickyClear    in   1      synchronous clear of the sticky mask
//   oStickyMask     out  WIDTH  sticky OR of oChangedMask, reset value 0
//   A change that lands in the same cycle as a clear is kept.
// ---------------------------------------------------------------------------
module switch_debouncer #(
  parameter int WIDTH        = 24,
  parameter int TICK_DIV     = 100000,
  parameter int STABLE_TICKS = 8
) (
  input  logic             iCpuClock,
  input  logic             iCpuReset,
  input  logic [WIDTH-1:0] iRawSwitches,
  output logic [WIDTH-1:0] oSwitches,
  output logic             oSwitchChanged,
  output logic [WIDTH-1:0] oChangedMask
`ifdef SWITCH_STICKY_EN
  ,
  input  logic             iStickyClear,
  output logic [WIDTH-1:0] oStickyMask
`endif
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = (STABLE_TICKS > 0) ? $clog2(STABLE_TICKS + 1) : 1;

  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

  // Synchroniser
  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;

  // Prescaler
  logic [PW-1:0] pre_q, pre_d;
  logic          tick;

  // Debounce state and registered outputs
  logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]         sw_q, sw_d;
  logic [WIDTH-1:0]         mask_q, mask_d;
  logic                     changed_q, changed_d;

  always_comb begin
    sync1_d = iRawSwitches;
    sync2_d = sync1_q;
  end

  // Free-running divider; tick is asserted for the whole cycle in which the
  // count sits at its last value, so exactly one tick per TICK_DIV cycles.
  always_comb begin
    tick  = (pre_q == PRE_LAST);
    pre_d = tick ? '0 : pre_q + PW'(1);
  end

  // Per-bit debounce. A match with the published value clears the count on
  // any cycle, tick or not, so a single glitch back restarts qualification.
  // Acceptance clears the count, which keeps it below STABLE_TICKS.
  always_comb begin
    sw_d   = sw_q;
    cnt_d  = cnt_q;
    mask_d = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (sync2_q[i] == sw_q[i]) begin
        cnt_d[i] = '0;
      end else if (tick) begin
        if (cnt_q[i] == CNT_LAST) begin
          sw_d[i]   = sync2_q[i];
          cnt_d[i]  = '0;
          mask_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
    changed_d = |mask_d;
  end

  always_ff @(posedge iCpuClock or posedge iCpuReset) begin
    if (iCpuReset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      pre_q     <= '0;
      cnt_q     <= '0;
      sw_q      <= '0;
      mask_q    <= '0;
      changed_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      pre_q     <= pre_d;
      cnt_q     <= cnt_d;
      sw_q      <= sw_d;
      mask_q    <= mask_d;
      changed_q <= changed_d;
    end
  end

  assign oSwitches      = sw_q;
  assign oChangedMask   = mask_q;
  assign oSwitchChanged = changed_q;

`ifdef SWITCH_STICKY_EN
  logic [WIDTH-1:0] sticky_q, sticky_d;

  // Clear first, then OR in the current pulse so a coincident change survives.
  always_comb begin
    sticky_d = (iStickyClear ? '0 : sticky_q) | mask_q;
  end

  always_ff @(posedge iCpuClock or posedge iCpuReset) begin
    if (iCpuReset) begin
      sticky_q <= '0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign oStickyMask = sticky_q;
`else
  // Sticky mask not built.
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
module tb_switch_debouncer;

  localparam int WIDTH        = 24;
  localparam int TICK_DIV     = 4;
  localparam int STABLE_TICKS = 3;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] sw;
  logic             chg;
  logic [WIDTH-1:0] mask;
`ifdef SWITCH_STICKY_EN
  logic             sclr;
  logic [WIDTH-1:0] sticky;
`endif

  switch_debouncer #(
    .WIDTH       (WIDTH),
    .TICK_DIV    (TICK_DIV),
    .STABLE_TICKS(STABLE_TICKS)
  ) dut (
    .iCpuClock     (clk),
    .iCpuReset     (rst),
    .iRawSwitches  (raw),
    .oSwitches     (sw),
    .oSwitchChanged(chg),
    .oChangedMask  (mask)
`ifdef SWITCH_STICKY_EN
    ,
    .iStickyClear  (sclr),
    .oStickyMask   (sticky)
`endif
  );

  typedef struct {
    int               cyc;     // cycle count at which the pulse must be seen
    int               issued;  // cycle count at which the raw edge was driven
    logic [WIDTH-1:0] sw;
    logic [WIDTH-1:0] mask;
  } exp_t;

  exp_t             q[$];
  exp_t             e;
  int               n_cmp = 0;
  int               n_bad = 0;
  int               cyc   = 0;
  int               pcnt;           // bench model of the sample prescaler
  logic [WIDTH-1:0] model_sw;       // accepted word once all pushed updates land
  logic [WIDTH-1:0] mon_sw;         // accepted word as seen by the monitor

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge rst) begin
    if (rst) pcnt <= 0;
    else     pcnt <= (pcnt == TICK_DIV - 1) ? 0 : pcnt + 1;
  end

  task automatic check(input string name, input logic [WIDTH-1:0] got,
                       input logic [WIDTH-1:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Expected update cycle: the raw edge reaches the sync output two cycles
  // after it is driven; the first tick cycle at or after that point counts
  // as tick 1 and the update registers one cycle after tick STABLE_TICKS.
  task automatic push_expect(input logic [WIDTH-1:0] v, output int exp_cyc);
    int   d;
    exp_t x;
    d        = (TICK_DIV - 1 - ((pcnt + 2) % TICK_DIV) + TICK_DIV) % TICK_DIV;
    x.cyc    = cyc + 3 + d + (STABLE_TICKS - 1) * TICK_DIV;
    x.issued = cyc;
    x.sw     = v;
    x.mask   = v ^ model_sw;
    model_sw = v;
    q.push_back(x);
    exp_cyc  = x.cyc;
  endtask

  task automatic issue(input logic [WIDTH-1:0] v, output int exp_cyc);
    push_expect(v, exp_cyc);
    raw = v;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 40 && q.size() != 0; k++) @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  // Monitor: checks pulse/mask agreement every cycle, pops the scoreboard on
  // each pulse, and flags a pulse that is overdue.
  always @(negedge clk) begin
    if (rst) begin
      mon_sw = '0;
    end else begin
      check("chg_vs_mask", {23'd0, chg}, {23'd0, |mask});
      if (chg) begin
        if (q.size() == 0) begin
          check("unexpected_pulse_mask", mask, '0);
        end else begin
          e = q.pop_front();
          check("pulse_cycle", WIDTH'(cyc), WIDTH'(e.cyc));
          check("pulse_latency_in_11_14",
                {23'd0, (cyc - e.issued) >= 11 && (cyc - e.issued) <= 14}, 24'd1);
          check("pulse_sw", sw, e.sw);
          check("pulse_mask", mask, e.mask);
          mon_sw = e.sw;
        end
      end else begin
        check("stable_sw", sw, mon_sw);
        if (q.size() != 0 && cyc > q[0].cyc) begin
          e = q.pop_front();
          check("missing_pulse_mask", mask, e.mask);
          mon_sw = e.sw;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int ex;
    rst      = 1'b1;
    raw      = '1;
    model_sw = '0;
    mon_sw   = '0;
`ifdef SWITCH_STICKY_EN
    sclr     = 1'b0;
`endif

    // 1: reset with all raw inputs high
    repeat (4) begin
      @(negedge clk);
      check("rst_sw", sw, '0);
      check("rst_chg", {23'd0, chg}, '0);
      check("rst_mask", mask, '0);
    end
    raw = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) begin @(posedge clk); end
    #1;

    // 2: single clean bit
    issue(24'h000001, ex);
    wait_idle();
    check("bit0_sw", sw, 24'h000001);

    // 3: short glitch on bit5 is rejected, a clean hold is accepted later
    raw = 24'h000021;
    repeat (6) @(posedge clk);
    #1;
    raw = 24'h000001;
    repeat (8) @(posedge clk);
    #1;
    check("glitch_sw", sw, 24'h000001);
    issue(24'h000021, ex);
    wait_idle();

    // 4: back to zero, then many bits at once
    issue(24'h000000, ex);
    wait_idle();
    issue(24'h3CA5A5, ex);
    wait_idle();
    check("multi_sw", sw, 24'h3CA5A5);

    // 5: reset mid-debounce discards the partial count
    raw = 24'h3CA5A7;
    repeat (10) @(posedge clk);
    #1;
    check("middeb_sw", sw, 24'h3CA5A5);
    rst = 1'b1;
    #1;
    check("midrst_sw", sw, '0);
    check("midrst_mask", mask, '0);
    check("midrst_chg", {23'd0, chg}, '0);
    @(posedge clk); #1;
    rst      = 1'b0;
    model_sw = '0;
    push_expect(24'h3CA5A7, ex);
    repeat (8) @(posedge clk);
    #1;
    check("postrst_sw", sw, '0);
    wait_idle();
    check("postrst_final_sw", sw, 24'h3CA5A7);

`ifdef SWITCH_STICKY_EN
    // 6: sticky mask
    sclr = 1'b1;
    @(posedge clk); #1;
    sclr = 1'b0;
    check("sticky_cleared", sticky, '0);
    issue(24'h3CA5AF, ex);
    wait_idle();
    check("sticky_bit3", sticky, 24'h000008);
    sclr = 1'b1;
    @(posedge clk); #1;
    sclr = 1'b0;
    check("sticky_clear_alone", sticky, '0);
    issue(24'h3CA52F, ex);
    for (int k = 0; k < 40 && cyc < ex; k++) begin
      @(posedge clk);
      #1;
    end
    sclr = 1'b1;
    @(posedge clk); #1;
    sclr = 1'b0;
    check("sticky_clear_with_pulse", sticky, 24'h000080);
    wait_idle();
`endif

    repeat (4) @(posedge clk);
    #1;
    check("queue_drained", WIDTH'(q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
